scan_buffer: RTL and testbench
==============================

Name: scan_buffer

Overview:
- Single scanner data-capture stage that sits directly upstream of the hex/count display logic in the lab3 top level.
- On a start_scan request it samples data_in into an internal buffer at a fixed rate, and reports fill level on data_count.
- When transfer_input is asserted it streams the buffered bytes in FIFO order to the peer stage over a valid/ready handshake.
- The peer stage is the second scanner buffer that drives data_count2.

Parameters:
- DEPTH, 100, buffer capacity in bytes; legal range 2..255.
- SAMPLE_DIV, 4, clk cycles between successive samples while scanning; legal range ≥1.
- READY_LEVEL, 80, fill level at which ready_flag asserts and a transfer may begin; must satisfy 1 ≤ READY_LEVEL ≤ DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_scan  input  1  scan request level; internally rising-edge detected.
- transfer_input  input  1  active-low transfer request level (1 = idle, 0 = request).
- data_in  input  8  sample byte, captured on each sample tick.
- xfer_ready  input  1  downstream accepts xfer_data this cycle.
- xfer_valid  output  1  xfer_data holds a valid byte.
- xfer_data  output  8  outgoing byte, oldest first.
- data_count  output  8  number of bytes currently held (0..DEPTH).
- ready_flag  output  1  high when data_count ≥ READY_LEVEL.
- full_flag  output  1  high when data_count == DEPTH.
- state  output  2  debug: 0 IDLE, 1 SCAN, 2 HOLD, 3 XFER.

Behaviour:
- Reset (async, any state): state = IDLE, data_count = 0, read/write pointers = 0, divider = 0, xfer_valid = 0, xfer_data = 0, ready_flag = 0, full_flag = 0, start_scan edge-detect register = 0. Buffer contents are don't-care.
- Output timing: ready_flag and full_flag are combinational from the registered data_count. All other outputs are registered.
- IDLE:
  - A start_scan rising edge (prev = 0, cur = 1) moves to SCAN next cycle and clears the divider.
  - transfer_input is ignored in IDLE.
- SCAN:
  - Divider counts 0..SAMPLE_DIV-1.
  - A sample tick occurs on the cycle the divider == SAMPLE_DIV-1. On a tick, data_in is written at the write pointer, the write pointer increments (wraps DEPTH-1 → 0), and data_count increments.
  - First sample lands SAMPLE_DIV cycles after entering SCAN.
  - When the write that makes data_count == DEPTH occurs, go to HOLD. No further writes happen; no overflow is ever possible.
  - If transfer_input == 0 and ready_flag == 1, go to XFER. This is checked before the sample tick in the same cycle, so no sample is taken that cycle.
  - Further start_scan edges are ignored.
- HOLD:
  - Scanning stops.
  - transfer_input == 0 moves to XFER next cycle.
- XFER:
  - On entry, xfer_data is loaded from the read pointer and xfer_valid = 1 on the first XFER cycle.
  - A beat completes when xfer_valid && xfer_ready. On completion, the read pointer increments (wraps), data_count decrements, and the next byte is presented the following cycle.
  - Back-to-back beats at 1 byte/cycle are supported while xfer_ready stays high.
  - While xfer_valid && !xfer_ready, xfer_data and xfer_valid hold stable.
  - On the beat that brings data_count to 0, xfer_valid drops next cycle and state returns to IDLE.
  - start_scan and transfer_input are ignored during XFER. Deasserting transfer_input does not abort a transfer.
- Simultaneous events:
  - The start_scan edge and the transfer condition are never both valid in the same state.
  - In SCAN, the transfer request wins over a sample tick.
- Width rule: data_count is 8 bits and never exceeds DEPTH ≤ 255; no wrap of the counter itself.
- Reset mid-operation (any state) discards all buffered data; data_count reads 0 on the first edge after rst deasserts.

Test Plan:
- Defaults, data_in = counter 0x00,0x01,…; pulse start_scan high for 2 cycles with transfer_input = 1 → data_count reaches 100 after 400 cycles; full_flag = 1; ready_flag = 1 from count 80; state = HOLD; data_count holds 100 while idle.
- From HOLD, drive transfer_input = 0 and xfer_ready = 1 → 100 consecutive beats with xfer_data 0x00..0x63 in order; data_count decrements 100 → 0; xfer_valid low after last beat; state = IDLE.
- Scan to 85 bytes, then transfer_input = 0 → scanning stops at 85 with no extra sample; 85 bytes transferred in order; final data_count = 0.
- During XFER, toggle xfer_ready 1,0,0,1,… → xfer_data/xfer_valid stable on stalled cycles; no byte dropped or duplicated; total accepted beats = initial data_count.
- Assert transfer_input = 0 at count 50 (below READY_LEVEL) → ignored; scan continues to 100. Hold start_scan high throughout the scan → no re-trigger; a fresh edge after return to IDLE starts a new scan.
- Assert rst for 1 cycle mid-XFER at count 40 → immediately data_count = 0, xfer_valid = 0, state = IDLE. A new scan/transfer cycle then works from pointer 0 with correct data ordering.

Source files
------------

// File: rtl/scan_buffer.sv
// scan_buffer: paced sample capture into a circular byte buffer, drained oldest-first over valid/ready.
module scan_buffer #(
    parameter int DEPTH       = 100,
    parameter int SAMPLE_DIV  = 4,
    parameter int READY_LEVEL = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_scan,
    input  logic       transfer_input,
    input  logic [7:0] data_in,
    input  logic       xfer_ready,
    output logic       xfer_valid,
    output logic [7:0] xfer_data,
    output logic [7:0] data_count,
    output logic       ready_flag,
    output logic       full_flag,
    output logic [1:0] state
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD, XFER} state_t;

    state_t        r_state;
    logic          r_start_prev;
    logic [DW-1:0] r_div;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [7:0]    r_count;
    logic          r_valid;
    logic [7:0]    r_data;
    logic [7:0]    r_mem [DEPTH];

    logic          w_start_edge;
    logic          w_tick;
    logic          w_to_xfer;
    logic          w_wr;
    logic          w_beat;
    logic [AW-1:0] w_wr_next;
    logic [AW-1:0] w_rd_next;

    assign w_start_edge = start_scan & ~r_start_prev;
    assign w_tick       = r_div == DIV_MAX;
    // A transfer request pre-empts the sample tick of the same cycle.
    assign w_to_xfer    = ~transfer_input & ((r_state == SCAN & ready_flag) | r_state == HOLD);
    assign w_wr         = r_state == SCAN & ~w_to_xfer & w_tick;
    assign w_beat       = r_state == XFER & r_valid & xfer_ready;
    assign w_wr_next    = r_wr_ptr == LAST ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_next    = r_rd_ptr == LAST ? '0 : r_rd_ptr + 1'b1;

    assign ready_flag = r_count >= 8'(READY_LEVEL);
    assign full_flag  = r_count == 8'(DEPTH);
    assign data_count = r_count;
    assign xfer_valid = r_valid;
    assign xfer_data  = r_data;
    assign state      = r_state;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_start_prev <= 1'b0;
            r_div        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_data       <= '0;
        end else begin
            r_start_prev <= start_scan;
            if (w_to_xfer) begin
                r_state <= XFER;
                r_valid <= 1'b1;
                r_data  <= r_mem[r_rd_ptr];
            end else begin
                case (r_state)
                    IDLE: if (w_start_edge) begin
                        r_state <= SCAN;
                        r_div   <= '0;
                    end
                    SCAN: if (w_tick) begin
                        r_div    <= '0;
                        r_wr_ptr <= w_wr_next;
                        r_count  <= r_count + 8'd1;
                        if (r_count == 8'(DEPTH - 1)) r_state <= HOLD;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                    HOLD: r_state <= HOLD;
                    XFER: if (w_beat) begin
                        r_rd_ptr <= w_rd_next;
                        r_count  <= r_count - 8'd1;
                        if (r_count == 8'd1) begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_data <= r_mem[w_rd_next];
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scan_buffer.sv
// tb_scan_buffer: directed scan/transfer scenarios plus random traffic against a queue-based model.
module tb_scan_buffer;
    localparam int DEPTH = 100;
    localparam int SD    = 4;
    localparam int RL    = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_scan;
    logic       transfer_input;
    logic [7:0] data_in;
    logic       xfer_ready;
    logic       xfer_valid;
    logic [7:0] xfer_data;
    logic [7:0] data_count;
    logic       ready_flag;
    logic       full_flag;
    logic [1:0] state;

    always #5 clk = ~clk;

    scan_buffer #(.DEPTH(DEPTH), .SAMPLE_DIV(SD), .READY_LEVEL(RL)) dut (
        .clk(clk), .rst(rst), .start_scan(start_scan), .transfer_input(transfer_input),
        .data_in(data_in), .xfer_ready(xfer_ready), .xfer_valid(xfer_valid), .xfer_data(xfer_data),
        .data_count(data_count), .ready_flag(ready_flag), .full_flag(full_flag), .state(state)
    );

    typedef struct {
        int req_at;
        int exp_count;
        int exp_state;
        bit stall;
        bit hold_start;
        bit no_rst;
    } vec_t;

    int n_checks = 0;
    int n_err = 0;
    bit rand_data = 0;

    // Reference model: buffer is a plain queue; mode 0 idle, 1 scan, 2 hold, 3 xfer.
    logic [7:0] q[$];
    int         m_mode;
    int         m_div;
    bit         m_prev;
    bit         m_valid;
    logic [7:0] m_data;
    int         wr_seq;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_mode = 0;
        m_div = 0;
        m_prev = 0;
        m_valid = 0;
        m_data = 0;
        wr_seq = 0;
    endfunction

    function automatic void model_update();
        bit edge_seen;
        edge_seen = start_scan && !m_prev;
        m_prev = start_scan;
        if (m_mode == 0) begin
            if (edge_seen) begin
                m_mode = 1;
                m_div = 0;
            end
        end else if (!transfer_input && ((m_mode == 1 && q.size() >= RL) || m_mode == 2)) begin
            m_mode = 3;
            m_valid = 1;
            m_data = q[0];
        end else if (m_mode == 1) begin
            if (m_div == SD - 1) begin
                m_div = 0;
                q.push_back(data_in);
                wr_seq++;
                if (q.size() == DEPTH) m_mode = 2;
            end else begin
                m_div++;
            end
        end else if (m_mode == 3 && m_valid && xfer_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                m_valid = 0;
                m_mode = 0;
            end else begin
                m_data = q[0];
            end
        end
    endfunction

    function automatic void compare_all();
        check("data_count", data_count, q.size());
        check("ready_flag", ready_flag, q.size() >= RL);
        check("full_flag", full_flag, q.size() == DEPTH);
        check("xfer_valid", xfer_valid, m_valid);
        check("state", state, m_mode);
        if (m_valid) check("xfer_data", xfer_data, m_data);
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_update();
        @(negedge clk);
        compare_all();
        if (!rand_data) data_in = wr_seq[7:0];
    endtask

    task automatic pulse_reset();
        rst = 1;
        #1;
        model_reset();
        check("rst_count", data_count, 0);
        check("rst_valid", xfer_valid, 0);
        check("rst_state", state, 0);
        step();
        rst = 0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] rx[$];
        bit reqd;
        int guard;
        if (!v.no_rst) pulse_reset();
        start_scan = 1;
        step();
        step();
        if (!v.hold_start) start_scan = 0;
        reqd = 0;
        guard = 0;
        while (m_mode == 1 && guard < 1000) begin
            if (v.req_at > 0 && !reqd && q.size() == v.req_at) begin
                transfer_input = 0;
                reqd = 1;
                step();
                transfer_input = 1;
            end else begin
                step();
            end
            guard++;
        end
        check("scan_end_count", data_count, v.exp_count);
        check("scan_end_state", state, v.exp_state);
        if (v.exp_state == 2) begin
            repeat (10) step();
            check("hold_count", data_count, v.exp_count);
            transfer_input = 0;
            step();
            transfer_input = 1;
        end
        guard = 0;
        while (m_mode == 3 && guard < 2000) begin
            xfer_ready = v.stall ? (guard % 3 == 0) : 1'b1;
            if (xfer_valid && xfer_ready) rx.push_back(xfer_data);
            step();
            guard++;
        end
        xfer_ready = 0;
        check("beats", rx.size(), v.exp_count);
        foreach (rx[i]) check("order", rx[i], i);
        check("drain_count", data_count, 0);
        check("drain_valid", xfer_valid, 0);
        check("drain_state", state, 0);
        if (v.hold_start) begin
            repeat (5) step();
            check("no_retrigger", state, 0);
            start_scan = 0;
            step();
            start_scan = 1;
            step();
            check("fresh_edge", state, 1);
            start_scan = 0;
        end
    endtask

    initial begin
        vec_t vecs[4];
        vec_t post_rst;
        int guard;
        vecs[0] = '{req_at: 0,  exp_count: 100, exp_state: 2, stall: 0, hold_start: 0, no_rst: 0};
        vecs[1] = '{req_at: 85, exp_count: 85,  exp_state: 3, stall: 0, hold_start: 0, no_rst: 0};
        vecs[2] = '{req_at: 80, exp_count: 80,  exp_state: 3, stall: 1, hold_start: 0, no_rst: 0};
        vecs[3] = '{req_at: 50, exp_count: 100, exp_state: 2, stall: 1, hold_start: 1, no_rst: 0};
        post_rst = '{req_at: 90, exp_count: 90, exp_state: 3, stall: 0, hold_start: 0, no_rst: 1};
        rst = 1;
        start_scan = 0;
        transfer_input = 1;
        xfer_ready = 0;
        data_in = 0;
        model_reset();
        @(negedge clk);
        pulse_reset();
        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a transfer, then a clean cycle from pointer 0.
        pulse_reset();
        start_scan = 1;
        step();
        step();
        start_scan = 0;
        guard = 0;
        while (m_mode == 1 && guard < 1000) begin
            step();
            guard++;
        end
        transfer_input = 0;
        step();
        transfer_input = 1;
        xfer_ready = 1;
        guard = 0;
        while (q.size() > 40 && guard < 200) begin
            step();
            guard++;
        end
        xfer_ready = 0;
        check("pre_rst_count", data_count, 40);
        pulse_reset();
        check("post_rst_count", data_count, 0);
        run_vec(post_rst);

        rand_data = 1;
        for (int i = 0; i < 4000; i++) begin
            start_scan = $urandom_range(0, 9) == 0;
            transfer_input = $urandom_range(0, 15) != 0;
            xfer_ready = $urandom_range(0, 2) != 0;
            data_in = 8'($urandom);
            if ($urandom_range(0, 799) == 0) pulse_reset();
            else step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
